// File: rtl/rr_x_in_pkg.sv
// Shared state encoding and helpers for the round-robin crossbar-input arbiter.
// Latency: none (types and pure functions only).
// Backpressure: n/a.
package rr_x_in_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANTED = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  // Binary index of a one-hot (or zero) vector; zero maps to index 0.
  function automatic logic [31:0] oh2bin(input logic [31:0] i_oh);
    logic [31:0] v_id;
    v_id = '0;
    for (int i = 0; i < 32; i++) begin
      if (i_oh[i]) v_id = v_id | 32'(i);
    end
    return v_id;
  endfunction

  // Pointer after granting requester i_id: one past it, wrapping at i_size.
  function automatic logic [31:0] ptr_next(input logic [31:0] i_id, input int i_size);
    return (i_id == 32'(i_size - 1)) ? 32'd0 : i_id + 32'd1;
  endfunction

endpackage

// File: rtl/rr_x_in_arbiter_if.sv
// Request/grant bundle between input-port request logic and the arbiter.
// Latency: n/a (wires only). last_in exists only with RR_X_IN_LOCK_EN.
// Backpressure: ack_in is the consumer's acknowledge of the held grant.
interface rr_x_in_arbiter_if #(
  parameter int IO_SIZE = 5,
  parameter int IO_w    = 3
);
  logic [IO_SIZE-1:0] req_in;
  logic               ack_in;
`ifdef RR_X_IN_LOCK_EN
  logic               last_in;
`endif
  logic [IO_SIZE-1:0] grant_out;
  logic               grant_vld;
  logic [IO_w-1:0]    grant_id;

  modport master (
    output req_in,
    output ack_in,
`ifdef RR_X_IN_LOCK_EN
    output last_in,
`endif
    input  grant_out,
    input  grant_vld,
    input  grant_id
  );

  modport slave (
    input  req_in,
    input  ack_in,
`ifdef RR_X_IN_LOCK_EN
    input  last_in,
`endif
    output grant_out,
    output grant_vld,
    output grant_id
  );
endinterface

// File: rtl/rr_x_in_arbiter_fpa.sv
// FPA_X_IN fixed-priority selector: keeps only the lowest set request bit.
// Latency: combinational.
// Backpressure: none.
module rr_x_in_arbiter_fpa #(
  parameter int N = 5
) (
  input  logic [N-1:0] i_req,
  output logic [N-1:0] o_gnt
);
  // x & ~(x-1) isolates the least significant set bit; zero in gives zero out.
  assign o_gnt = i_req & ~(i_req - N'(1));
endmodule

// File: rtl/rr_x_in_arbiter.sv
// Round-robin N-input arbiter producing a registered one-hot grant; build option RR_X_IN_LOCK_EN.
// Latency: request to grant 1 cycle; back-to-back grants on ack with no bubble.
// Backpressure: grant held until ack_in (and last_in when locking is enabled).
module rr_x_in_arbiter #(
  parameter int IO_SIZE = 5,
  parameter int IO_w    = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  rr_x_in_arbiter_if.slave  bus
);
  import rr_x_in_pkg::*;

  logic [1:0]         r_state;
  logic [1:0]         w_state_nxt;
  logic [IO_SIZE-1:0] r_grant;
  logic [IO_SIZE-1:0] w_grant_nxt;
  logic [IO_w-1:0]    r_grant_id;
  logic [IO_w-1:0]    w_grant_id_nxt;
  logic [IO_w-1:0]    r_ptr;
  logic [IO_w-1:0]    w_ptr_nxt;
  logic [IO_w-1:0]    w_ptr_adv;
  logic [IO_w-1:0]    w_arb_ptr;

  logic               w_req_any;
  logic               w_release;
  logic               w_gnt_dropped;
`ifdef RR_X_IN_LOCK_EN
  logic               w_lock;
`endif

  logic [IO_SIZE-1:0] w_mask;
  logic [IO_SIZE-1:0] w_masked;
  logic [IO_SIZE-1:0] w_sel_masked;
  logic [IO_SIZE-1:0] w_sel_raw;
  logic [IO_SIZE-1:0] w_arb_gnt;
  logic [IO_w-1:0]    w_arb_id;

  assign w_req_any     = |bus.req_in;
  assign w_ptr_adv     = IO_w'(ptr_next(32'(r_grant_id), IO_SIZE));
  // Cancel only applies without ack; ack plus a dropped bit is a release.
  assign w_gnt_dropped = (r_state == ST_GRANTED) && !bus.ack_in && ((r_grant & bus.req_in) == '0);

`ifdef RR_X_IN_LOCK_EN
  assign w_release = bus.ack_in && bus.last_in &&
                     ((r_state == ST_GRANTED) || (r_state == ST_LOCKED));
  assign w_lock    = bus.ack_in && !bus.last_in && (r_state == ST_GRANTED);
`else
  assign w_release = bus.ack_in && (r_state == ST_GRANTED);
`endif

  // On release, arbitrate from the advanced pointer so the next grant lands on the same edge.
  assign w_arb_ptr = w_release ? w_ptr_adv : r_ptr;

  // Thermometer mask: keep requesters at or above the pointer.
  always_comb begin
    w_mask = '0;
    for (int j = 0; j < IO_SIZE; j++) begin
      w_mask[j] = (j >= int'(w_arb_ptr));
    end
  end

  assign w_masked = bus.req_in & w_mask;

  rr_x_in_arbiter_fpa #(.N(IO_SIZE)) u_fpa_masked (
    .i_req (w_masked),
    .o_gnt (w_sel_masked)
  );

  rr_x_in_arbiter_fpa #(.N(IO_SIZE)) u_fpa_raw (
    .i_req (bus.req_in),
    .o_gnt (w_sel_raw)
  );

  // Wrap to the unmasked pick when nobody at/above the pointer is requesting.
  assign w_arb_gnt = (|w_masked) ? w_sel_masked : w_sel_raw;
  assign w_arb_id  = IO_w'(oh2bin(32'(w_arb_gnt)));

  // State, grant, grant id and pointer registers; id always moves with the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_grant    <= '0;
      r_grant_id <= '0;
      r_ptr      <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_grant    <= w_grant_nxt;
      r_grant_id <= w_grant_id_nxt;
      r_ptr      <= w_ptr_nxt;
    end
  end

  // Next-state: grant on request, re-arbitrate on release or cancel, otherwise hold.
  always_comb begin
    w_state_nxt    = r_state;
    w_grant_nxt    = r_grant;
    w_grant_id_nxt = r_grant_id;
    w_ptr_nxt      = r_ptr;
    case (r_state)
      ST_IDLE: begin
        if (w_req_any) begin
          w_grant_nxt    = w_arb_gnt;
          w_grant_id_nxt = w_arb_id;
          w_state_nxt    = ST_GRANTED;
        end
      end
      ST_GRANTED: begin
        if (w_release) begin
          w_ptr_nxt      = w_ptr_adv;
          w_grant_nxt    = w_arb_gnt;
          w_grant_id_nxt = w_arb_id;
          w_state_nxt    = w_req_any ? ST_GRANTED : ST_IDLE;
`ifdef RR_X_IN_LOCK_EN
        end else if (w_lock) begin
          w_state_nxt    = ST_LOCKED;
`endif
        end else if (w_gnt_dropped) begin
          w_grant_nxt    = w_arb_gnt;
          w_grant_id_nxt = w_arb_id;
          w_state_nxt    = w_req_any ? ST_GRANTED : ST_IDLE;
        end
      end
`ifdef RR_X_IN_LOCK_EN
      ST_LOCKED: begin
        if (w_release) begin
          w_ptr_nxt      = w_ptr_adv;
          w_grant_nxt    = w_arb_gnt;
          w_grant_id_nxt = w_arb_id;
          w_state_nxt    = w_req_any ? ST_GRANTED : ST_IDLE;
        end
      end
`endif
      default: begin
        w_state_nxt    = ST_IDLE;
        w_grant_nxt    = '0;
        w_grant_id_nxt = '0;
      end
    endcase
  end

  // Outputs come straight from registers, so they cannot glitch.
  always_comb begin
    bus.grant_out = r_grant;
    bus.grant_vld = |r_grant;
    bus.grant_id  = r_grant_id;
  end

endmodule

// File: tb/tb_rr_x_in_arbiter.sv
// Directed bench for rr_x_in_arbiter with a queue of expected grants per step.
// Latency: each step's expectation is checked 1 ns after the following rising edge.
// Backpressure: ack_in driven by the step table.
module tb_rr_x_in_arbiter;
  logic clk;
  logic rst_n;
  logic last_drv;

  int vectors;
  int miscompares;

  logic [4:0] sb_q[$];
  string      tag_q[$];

  rr_x_in_arbiter_if #(.IO_SIZE(5), .IO_w(3)) bus ();

`ifdef RR_X_IN_LOCK_EN
  assign bus.last_in = last_drv;
`endif

  rr_x_in_arbiter #(.IO_SIZE(5), .IO_w(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_id_of(input logic [4:0] g);
    logic [31:0] v;
    v = 0;
    for (int i = 0; i < 5; i++) if (g[i]) v = 32'(i);
    return v;
  endfunction

  task automatic check_out();
    logic [4:0] e;
    string      t;
    if (sb_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_empty observed=0 expected=1");
    end else begin
      e = sb_q.pop_front();
      t = tag_q.pop_front();
      cmp(32'(bus.grant_out), 32'(e), {t, "_grant"});
      cmp(32'(bus.grant_vld), 32'(|e), {t, "_vld"});
      cmp(32'(bus.grant_id), exp_id_of(e), {t, "_id"});
    end
  endtask

  task automatic step(input logic [4:0] req, input logic ack, input logic last,
                      input logic [4:0] exp, input string tag);
    @(negedge clk);
    bus.req_in = req;
    bus.ack_in = ack;
    last_drv   = last;
    sb_q.push_back(exp);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
    check_out();
  endtask

  task automatic check_zero(input string tag);
    cmp(32'(bus.grant_out), 32'd0, {tag, "_grant"});
    cmp(32'(bus.grant_vld), 32'd0, {tag, "_vld"});
    cmp(32'(bus.grant_id), 32'd0, {tag, "_id"});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus.req_in  = '0;
    bus.ack_in  = 1'b0;
    last_drv    = 1'b0;

    #12;
    check_zero("rst_init");
    @(negedge clk);
    rst_n = 1'b1;

    // 1. Reset: move ptr to 1, then reset mid-grant and confirm ptr returns to 0
    step(5'b00001, 1'b0, 1'b0, 5'b00001, "t1_first");
    step(5'b00001, 1'b1, 1'b0, 5'b00001, "t1_adv");
    #2;
    rst_n = 1'b0;
    #1;
    check_zero("t1_rst_async");
    @(negedge clk);
    bus.req_in = '0;
    bus.ack_in = 1'b0;
    rst_n      = 1'b1;
    step(5'b00011, 1'b0, 1'b0, 5'b00001, "t1_rst_ptr0");
    step(5'b00000, 1'b1, 1'b0, 5'b00000, "t1_to_idle");

    // 2. Rotation over 10110 with ack on every grant
    step(5'b10110, 1'b0, 1'b0, 5'b00010, "t2_g1");
    step(5'b10110, 1'b1, 1'b0, 5'b00100, "t2_g2");
    step(5'b10110, 1'b1, 1'b0, 5'b10000, "t2_g4");
    step(5'b10110, 1'b1, 1'b0, 5'b00010, "t2_wrap");

    // 3. Cancel: granted bit2 dropped without ack
    step(5'b10110, 1'b1, 1'b0, 5'b00100, "t3_g2");
    step(5'b10010, 1'b0, 1'b0, 5'b10000, "t3_cancel");
    step(5'b10010, 1'b1, 1'b0, 5'b00010, "t3_after");
    step(5'b10011, 1'b0, 1'b0, 5'b00010, "t3_hold_other");
    step(5'b00010, 1'b0, 1'b0, 5'b00010, "t3_hold_drop_other");
    step(5'b00000, 1'b1, 1'b0, 5'b00000, "t3_idle");

    // 4. Single requester acked every cycle
    step(5'b00001, 1'b0, 1'b0, 5'b00001, "t4_first");
    for (int k = 0; k < 4; k++) begin
      step(5'b00001, 1'b1, 1'b0, 5'b00001, "t4_repeat");
    end
    step(5'b10000, 1'b1, 1'b0, 5'b10000, "t4_g4");
    step(5'b00000, 1'b1, 1'b0, 5'b00000, "t4_idle_ptr0");

    // 5. Spurious ack while idle must not move ptr
    step(5'b00000, 1'b1, 1'b0, 5'b00000, "t5_spur_a");
    step(5'b00000, 1'b1, 1'b0, 5'b00000, "t5_spur_b");
    step(5'b00011, 1'b0, 1'b0, 5'b00001, "t5_grant");

`ifdef RR_X_IN_LOCK_EN
    // 6. Lock: acks without last hold grant; LOCKED ignores req changes
    step(5'b00011, 1'b1, 1'b0, 5'b00001, "t6_lock1");
    step(5'b00011, 1'b1, 1'b0, 5'b00001, "t6_lock2");
    step(5'b00011, 1'b1, 1'b0, 5'b00001, "t6_lock3");
    step(5'b00010, 1'b0, 1'b0, 5'b00001, "t6_lock_req_chg");
    step(5'b00011, 1'b1, 1'b1, 5'b00010, "t6_release");
`else
    // Without locking every ack is a release
    step(5'b00011, 1'b1, 1'b0, 5'b00010, "t6_release");
`endif

    if (sb_q.size() != 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_leftover observed=%0d expected=0", sb_q.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
